byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/serial_pkg.sv | 12 +
 rtl/skid_hold.sv | 44 ++++
 rtl/byte_serializer.sv | 103 ++++++++++
 tb/tb_byte_serializer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-stream path: serializer FSM states
// and the default word width used by the serializer and detector stages.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/skid_hold.sv
// One-entry hold register in front of the serializer's shifter. Ready is a
// pure function of the registered full flag, so there is no path from in_valid.
module skid_hold
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  assign w_accept  = in_valid && !r_full;
  assign in_ready  = !r_full;
  assign hold_full = r_full;
  assign hold_data = r_data;

  // Accept and take are mutually exclusive: take needs r_full, accept needs !r_full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      // NOTE: the data register is reset too; it is a single word, so the cost is
      // trivial and the contents stay deterministic after reset.
      r_data <= '0;
    end else if (w_accept) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_full <= 1'b1;
      r_data <= in_data;
    end else if (take) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: one bit per en strobe, with a one-word hold
// buffer so consecutive words stream with no gap between them.
module byte_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_x;
  logic             r_x_valid;
  logic             r_frame_start;

  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_full;
  logic             w_take;
  logic             w_last;
  logic             w_bit;

  skid_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .take     (w_take),
    .hold_data(w_hold_data),
    .hold_full(w_hold_full)
  );

  assign w_last = (r_cnt == LAST);
  assign w_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  // The hold word moves either into an empty shifter or on the last bit's strobe.
  assign w_take = w_hold_full &&
                  ((r_state == IDLE) || ((r_state == SHIFT) && en && w_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_x           <= 1'b0;
      r_x_valid     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x_valid     <= 1'b0;
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hold_full) begin
            r_shift <= w_hold_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            r_x           <= w_bit;
            r_x_valid     <= 1'b1;
            r_frame_start <= (r_cnt == '0);
            if (w_last) begin
              r_cnt <= '0;
              if (w_hold_full) begin
                r_shift <= w_hold_data;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x           = r_x;
  assign x_valid     = r_x_valid;
  assign frame_start = r_frame_start;
  assign busy        = (r_state == SHIFT) || w_hold_full;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: two instances (MSB-first and
// LSB-first) share stimulus; a word-level scoreboard checks every serial bit.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic m_in_ready, m_x, m_x_valid, m_frame_start, m_busy;
  logic l_in_ready, l_x, l_x_valid, l_frame_start, l_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_period = 1;  // 0: en held low, <0: random, N>0: en high once every N cycles
  int acc_cnt = 0;
  int acc_pulses = 0;
  logic prev_en = 1'b0;

  typedef struct {
    logic x;
    logic fs;
    int   t;
  } pulse_t;

  typedef struct {
    logic b;
    logic fs;
  } ebit_t;

  typedef struct {
    logic [7:0] data;
    int         period;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  pulse_t pm[$];
  pulse_t pl[$];
  ebit_t  em[$];
  ebit_t  el[$];
  ebit_t  eb;
  vec_t   vecs[5];

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .en(en), .x(m_x), .x_valid(m_x_valid),
    .frame_start(m_frame_start), .busy(m_busy)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .en(en), .x(l_x), .x_valid(l_x_valid),
    .frame_start(l_frame_start), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en_period == 0)     en = 1'b0;
    else if (en_period < 0) en = ($urandom_range(0, 1) == 1);
    else                    en = ((cyc % en_period) == 0);
    cyc++;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    pm.delete();
    pl.delete();
    acc_cnt = 0;
  endtask

  task automatic send(input logic [7:0] w);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!m_in_ready && k < 500) begin
      step();
      k++;
    end
    if (k >= 500) check("send_ready_timeout", m_in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int k;
    k = 0;
    while (!(pm.size() >= n && pl.size() >= n && !m_busy && !l_busy) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) check("drain_timeout", pm.size(), n);
  endtask

  task automatic check_pulses(input bit sel, input string tag, input int n,
                              input logic [31:0] bits, input int period);
    pulse_t q[$];
    if (sel) q = pl;
    else     q = pm;
    check({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("%s_bit%0d", tag, i), q[i].x, bits[n-1-i]);
      check($sformatf("%s_fs%0d", tag, i), q[i].fs, (i % 8) == 0);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), q[i].t - q[i-1].t, period);
    end
  endtask

  // Scoreboard: every accepted word expands into 8 expected bits per bit order.
  always @(negedge clk) begin
    if (!rst_n) begin
      em.delete();
      el.delete();
    end else begin
      if (m_x_valid) begin
        pm.push_back('{x: m_x, fs: m_frame_start, t: int'($time / 10)});
        check("sb_m_pending", em.size() > 0, 1);
        if (em.size() > 0) begin
          eb = em.pop_front();
          check("sb_m_bit", m_x, eb.b);
          check("sb_m_fs", m_frame_start, eb.fs);
        end
        check("en_gate_m", prev_en, 1);
      end else if (m_frame_start) begin
        check("fs_without_valid_m", m_x_valid, 1);
      end
      if (l_x_valid) begin
        pl.push_back('{x: l_x, fs: l_frame_start, t: int'($time / 10)});
        check("sb_l_pending", el.size() > 0, 1);
        if (el.size() > 0) begin
          eb = el.pop_front();
          check("sb_l_bit", l_x, eb.b);
          check("sb_l_fs", l_frame_start, eb.fs);
        end
        check("en_gate_l", prev_en, 1);
      end else if (l_frame_start) begin
        check("fs_without_valid_l", l_x_valid, 1);
      end
      if (in_valid && m_in_ready) begin
        acc_cnt++;
        acc_pulses = pm.size();
        for (int i = 7; i >= 0; i--) em.push_back('{b: in_data[i], fs: (i == 7)});
        for (int i = 0; i < 8; i++)  el.push_back('{b: in_data[i], fs: (i == 0)});
      end
    end
    prev_en = en;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, period: 1, exp_m: 8'b10100101, exp_l: 8'b10100101};
    vecs[1] = '{data: 8'hF0, period: 3, exp_m: 8'b11110000, exp_l: 8'b00001111};
    vecs[2] = '{data: 8'h01, period: 1, exp_m: 8'b00000001, exp_l: 8'b10000000};
    vecs[3] = '{data: 8'h0A, period: 2, exp_m: 8'b00001010, exp_l: 8'b01010000};
    vecs[4] = '{data: 8'h3C, period: 4, exp_m: 8'b00111100, exp_l: 8'b00111100};

    // Reset state
    #12;
    check("rst_in_ready_m", m_in_ready, 1);
    check("rst_busy_m", m_busy, 0);
    check("rst_x_m", m_x, 0);
    check("rst_xv_m", m_x_valid, 0);
    check("rst_fs_m", m_frame_start, 0);
    check("rst_in_ready_l", l_in_ready, 1);
    check("rst_busy_l", l_busy, 0);
    check("rst_xv_l", l_x_valid, 0);

    // Single words, assorted bit patterns and en cadences
    for (int v = 0; v < 5; v++) begin
      en_period = vecs[v].period;
      reset_dut();
      send(vecs[v].data);
      wait_drain(8);
      check_pulses(1'b0, $sformatf("vec%0d_m", v), 8, {24'h0, vecs[v].exp_m}, vecs[v].period);
      check_pulses(1'b1, $sformatf("vec%0d_l", v), 8, {24'h0, vecs[v].exp_l}, vecs[v].period);
      check($sformatf("vec%0d_busy_end", v), m_busy, 0);
      check($sformatf("vec%0d_ready_end", v), m_in_ready, 1);
    end

    // Back-to-back words stream contiguously
    en_period = 1;
    reset_dut();
    send(8'h0A);
    send(8'hAA);
    wait_drain(16);
    check_pulses(1'b0, "b2b_m", 16, 32'h0000_0AAA, 1);
    check_pulses(1'b1, "b2b_l", 16, 32'h0000_5055, 1);

    // en held low: shifter and hold fill, third word waits for the hold to drain
    en_period = 0;
    reset_dut();
    send(8'hC3);
    send(8'h5A);
    in_valid = 1'b1;
    in_data  = 8'h96;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_ready%0d", i), m_in_ready, 0);
      check($sformatf("stall_busy%0d", i), m_busy, 1);
    end
    check("stall_no_pulses", pm.size(), 0);
    en_period = 1;
    begin
      int k;
      k = 0;
      while (!m_in_ready && k < 200) begin
        step();
        k++;
      end
      if (k >= 200) check("stall_resume_timeout", m_in_ready, 1);
    end
    step();
    in_valid = 1'b0;
    check("stall_w3_after_w1", acc_pulses, 8);
    wait_drain(24);
    check_pulses(1'b0, "stall_m", 24, 32'h00C3_5A96, 1);
    check_pulses(1'b1, "stall_l", 24, 32'h00C3_5A69, 1);

    // Reset mid-word with a second word held
    en_period = 1;
    reset_dut();
    send(8'hA5);
    send(8'h3C);
    begin
      int k;
      k = 0;
      while (pm.size() < 3 && k < 200) begin
        step();
        k++;
      end
    end
    check("midrst_hold_full", m_in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_xv_m", m_x_valid, 0);
    check("midrst_fs_m", m_frame_start, 0);
    check("midrst_ready_m", m_in_ready, 1);
    check("midrst_busy_m", m_busy, 0);
    check("midrst_busy_l", l_busy, 0);
    step();
    step();
    rst_n = 1'b1;
    pm.delete();
    pl.delete();
    for (int i = 0; i < 40; i++) step();
    check("midrst_residual_m", pm.size(), 0);
    check("midrst_residual_l", pl.size(), 0);
    check("midrst_idle_busy", m_busy, 0);

    // Randomized traffic against the word-level scoreboard
    en_period = -1;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    en_period = 1;
    begin
      int k;
      k = 0;
      while ((em.size() > 0 || el.size() > 0 || m_busy || l_busy) && k < 2000) begin
        step();
        k++;
      end
    end
    step();
    check("rand_exp_empty_m", em.size(), 0);
    check("rand_exp_empty_l", el.size(), 0);
    check("rand_pulse_total_m", pm.size(), acc_cnt * 8);
    check("rand_pulse_total_l", pl.size(), acc_cnt * 8);
    check("rand_busy_end", m_busy, 0);
    check("rand_words_seen", acc_cnt > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
